// File: rtl/ibuf_reader.sv
// ibuf_reader: read side of the ping-pong input buffer.
// Walks the conv window per tile and streams POY-wide words to the PE array.
`timescale 1ns/1ps

module ibuf_reader #(
    parameter int DW     = 32,
    parameter int STRIDE = 1,
    parameter int KSIZE  = 3,
    parameter int BURST  = 32,
    parameter int POX    = 16,
    parameter int POY    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                tile_ready,
    output logic                tile_release,
    output logic                ren,
    output logic [7:0]          rrow,
    output logic [27:0]         rcol,
    input  logic [POY*DW-1:0]   rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [POY*DW-1:0]   out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int OXW = (POX > 1) ? $clog2(POX) : 1;
    localparam int KW  = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    // The widest column touched by the window must stay inside one buffer row.
    generate
        if ((POX - 1) * STRIDE + KSIZE - 1 > BURST - 1) begin : g_bad_cfg
            $fatal(1, "ibuf_reader: window columns exceed BURST");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OXW-1:0] ox;
    logic [KW-1:0]  kx;
    logic [KW-1:0]  ky;
    logic [7:0]     base;
    logic [7:0]     row_q;
    logic [27:0]    col_q;
    logic [7:0]     cur_row;
    logic [27:0]    cur_col;
    logic           ox_last;
    logic           kx_last;
    logic           ky_last;
    logic           final_addr;

    logic [POY*DW-1:0] mem_data [2];
    logic              mem_last [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              inflight;
    logic              inflight_last;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic              drain_empty;

    assign ox_last    = (ox == OXW'(POX - 1));
    assign kx_last    = (kx == KW'(KSIZE - 1));
    assign ky_last    = (ky == KW'(KSIZE - 1));
    assign final_addr = ox_last && kx_last && ky_last;

    assign cur_row = base + 8'(ky);
    assign cur_col = 28'(ox) * 28'(STRIDE) + 28'(kx);

    assign push      = inflight;
    assign pop       = out_valid && out_ready;
    // Words held plus words in flight, minus the one leaving now, must leave a slot.
    assign credit_ok = ({1'b0, count} + {2'b00, inflight})
                       < (3'd2 + {2'b00, pop});
    assign drain_empty = !inflight
                         && ((count == 2'd0) || (count == 2'd1 && pop));

    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_last  = out_valid && mem_last[rd_ptr];

    // Idle addresses hold the last issued value rather than the next one.
    assign rrow = ren ? cur_row : row_q;
    assign rcol = ren ? cur_col : col_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT:  if (tile_ready) state_nxt = S_READ;
            S_READ:  if (ren && final_addr) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_empty) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        ren          = (state == S_READ) && credit_ok;
        busy         = (state != S_IDLE);
        done         = (state == S_FIN);
        tile_release = (state == S_FIN);
    end

    // Window walk: ox innermost, then kx, then ky; wraps to 0 after the last read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ox <= '0;
            kx <= '0;
            ky <= '0;
        end else if (ren) begin
            if (!ox_last) begin
                ox <= ox + 1'b1;
            end else begin
                ox <= '0;
                if (!kx_last) begin
                    kx <= kx + 1'b1;
                end else begin
                    kx <= '0;
                    ky <= ky_last ? '0 : ky + 1'b1;
                end
            end
        end
    end

    // Remember the last issued address so idle cycles hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (ren) begin
            row_q <= cur_row;
            col_q <= cur_col;
        end
    end

    // Row base flips between the two buffer halves on each finished tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
        end else if (state == S_FIN) begin
            base <= (base == 8'd0) ? 8'(STRIDE) : 8'd0;
        end
    end

    // Track the read whose data lands next cycle, with its end-of-tile tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ren;
            inflight_last <= ren && final_addr;
        end
    end

    // Two-entry output FIFO fed by the bank read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= rdata;
                mem_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
